// File: rtl/calc2_pkg.sv
`default_nettype none
// calc2_pkg -- shared command/response encodings and pipeline stage type for calc2 ports (rev 1.0)
package calc2_pkg;

  localparam int CALC2_DATA_W = 32;
  localparam int CALC2_TAG_W  = 2;

  typedef enum logic [3:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_SHL = 4'd5,
    CMD_SHR = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_ERR  = 2'd2
  } resp_e;

  typedef struct packed {
    logic                    valid;
    resp_e                   resp;
    logic [CALC2_DATA_W-1:0] data;
    logic [CALC2_TAG_W-1:0]  tag;
  } pipe_stage_t;

endpackage
`default_nettype wire

// File: rtl/calc2_alu.sv
`default_nettype none
// calc2_alu -- combinational add/sub/shift with error classification; errors always return data 0 (rev 1.0)
module calc2_alu
  import calc2_pkg::*;
#(
  parameter int DATA_W = CALC2_DATA_W
) (
  input  logic [3:0]        i_cmd,
  input  logic [DATA_W-1:0] i_op1,
  input  logic [DATA_W-1:0] i_op2,
  output resp_e             o_resp,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W:0] w_sum;
  logic [4:0]      w_sh;

  always_comb begin
    w_sum  = {1'b0, i_op1} + {1'b0, i_op2};
    w_sh   = i_op2[4:0];
    o_resp = RESP_ERR;
    o_data = '0;
    case (i_cmd)
      CMD_ADD: begin
        if (!w_sum[DATA_W]) begin
          o_resp = RESP_OK;
          o_data = w_sum[DATA_W-1:0];
        end
      end
      CMD_SUB: begin
        if (i_op2 <= i_op1) begin
          o_resp = RESP_OK;
          o_data = i_op1 - i_op2;
        end
      end
      CMD_SHL: begin
        o_resp = RESP_OK;
        o_data = i_op1 << w_sh;
      end
      CMD_SHR: begin
        o_resp = RESP_OK;
        o_data = i_op1 >> w_sh;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/calc2_port_responder.sv
`default_nettype none
// calc2_port_responder -- single calc2 port: two-cycle request capture, ALU_LAT-stage in-order result pipe (rev 1.0)
// Define CALC2_TAG_CHECK_EN to reject requests whose tag is still outstanding.
module calc2_port_responder
  import calc2_pkg::*;
#(
  parameter int DATA_W  = CALC2_DATA_W,
  parameter int TAG_W   = CALC2_TAG_W,
  parameter int ALU_LAT = 3
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [3:0]        req_cmd_in,
  input  logic [DATA_W-1:0] req_data_in,
  input  logic [TAG_W-1:0]  req_tag_in,
  output logic [1:0]        out_resp,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag
);

  typedef struct packed {
    logic              valid;
    resp_e             resp;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } stage_t;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OP2  = 1'b1;

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic              w_accept;
  logic              w_push;
  logic              w_dup;
  logic [3:0]        r_cmd;
  logic [DATA_W-1:0] r_op1;
  logic [TAG_W-1:0]  r_tag;
  logic              r_dup;
  resp_e             w_alu_resp;
  logic [DATA_W-1:0] w_alu_data;
  stage_t            r_pipe [ALU_LAT];
  logic              w_out_valid;

  always_ff @(posedge c_clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (req_cmd_in != 4'd0) w_state_nxt = ST_OP2;
      ST_OP2:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_accept = (r_state == ST_IDLE) && (req_cmd_in != 4'd0);
    w_push   = (r_state == ST_OP2);
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      r_cmd <= '0;
      r_op1 <= '0;
      r_tag <= '0;
      r_dup <= 1'b0;
    end else if (w_accept) begin
      r_cmd <= req_cmd_in;
      r_op1 <= req_data_in;
      r_tag <= req_tag_in;
      r_dup <= w_dup;
    end
  end

  // Operand 2 is consumed straight off the bus in the OP2 cycle.
  calc2_alu #(.DATA_W(DATA_W)) u_alu (
    .i_cmd  (r_cmd),
    .i_op1  (r_op1),
    .i_op2  (req_data_in),
    .o_resp (w_alu_resp),
    .o_data (w_alu_data)
  );

  always_ff @(posedge c_clk) begin
    if (reset) begin
      for (int i = 0; i < ALU_LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0].valid <= w_push;
      r_pipe[0].resp  <= r_dup ? RESP_ERR : w_alu_resp;
      r_pipe[0].data  <= r_dup ? '0 : w_alu_data;
      r_pipe[0].tag   <= r_tag;
      for (int i = 1; i < ALU_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  // Reset suppresses a response even in the cycle it would have been presented.
  assign w_out_valid = r_pipe[ALU_LAT-1].valid && !reset;

  always_comb begin
    out_resp = '0;
    out_data = '0;
    out_tag  = '0;
    if (w_out_valid) begin
      out_resp = r_pipe[ALU_LAT-1].resp;
      out_data = r_pipe[ALU_LAT-1].data;
      out_tag  = r_pipe[ALU_LAT-1].tag;
    end
  end

`ifdef CALC2_TAG_CHECK_EN
  logic [(1<<TAG_W)-1:0] r_busy;
  logic [(1<<TAG_W)-1:0] w_busy_nxt;
  logic [ALU_LAT-1:0]    r_owner;
  logic                  w_free;

  // Only the request that set a tag's busy bit may clear it; rejected duplicates ride along as non-owners.
  assign w_free = w_out_valid && r_owner[ALU_LAT-1];
  assign w_dup  = r_busy[req_tag_in] && !(w_free && (out_tag == req_tag_in));

  always_comb begin
    w_busy_nxt = r_busy;
    if (w_free) w_busy_nxt[out_tag] = 1'b0;
    if (w_accept && !w_dup) w_busy_nxt[req_tag_in] = 1'b1;
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      r_busy  <= '0;
      r_owner <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_owner[0] <= w_push && !r_dup;
      for (int i = 1; i < ALU_LAT; i++) r_owner[i] <= r_owner[i-1];
    end
  end
`else
  assign w_dup = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_calc2_port_responder.sv
`default_nettype none
`timescale 1ns/1ps
// tb_calc2_port_responder -- directed and randomized requests against a cycle-indexed expectation table.
module tb_calc2_port_responder;
  import calc2_pkg::*;

  localparam int DW   = 32;
  localparam int TW   = 2;
  localparam int LAT  = 3;
  localparam int MAXC = 8192;

  logic          c_clk       = 1'b0;
  logic          reset       = 1'b1;
  logic [3:0]    req_cmd_in  = '0;
  logic [DW-1:0] req_data_in = '0;
  logic [TW-1:0] req_tag_in  = '0;
  logic [1:0]    out_resp;
  logic [DW-1:0] out_data;
  logic [TW-1:0] out_tag;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  pipe_stage_t expq [MAXC];
  int owner_cyc [4];

  calc2_port_responder #(.DATA_W(DW), .TAG_W(TW), .ALU_LAT(LAT)) dut (
    .c_clk       (c_clk),
    .reset       (reset),
    .req_cmd_in  (req_cmd_in),
    .req_data_in (req_data_in),
    .req_tag_in  (req_tag_in),
    .out_resp    (out_resp),
    .out_data    (out_data),
    .out_tag     (out_tag)
  );

  always #5 c_clk = ~c_clk;
  always @(posedge c_clk) cyc <= cyc + 1;

  // Spec-level result of one request, ignoring tags/latency.
  function automatic pipe_stage_t model_op(input logic [3:0] cmd, input logic [31:0] a,
                                           input logic [31:0] b, input logic [1:0] tag);
    pipe_stage_t s;
    longint unsigned total;
    int sh;
    s       = '0;
    s.valid = 1'b1;
    s.tag   = tag;
    s.resp  = RESP_ERR;
    sh      = int'(b % 32);
    total   = longint'(a) + longint'(b);
    case (cmd)
      4'd1: if (total <= 64'hFFFF_FFFF) begin s.resp = RESP_OK; s.data = total[31:0]; end
      4'd2: if (b <= a) begin s.resp = RESP_OK; s.data = a - b; end
      4'd5: begin s.resp = RESP_OK; s.data = a << sh; end
      4'd6: begin s.resp = RESP_OK; s.data = a >> sh; end
      default: ;
    endcase
    return s;
  endfunction

  always @(negedge c_clk) begin : b_cmp
    logic [1:0]    er;
    logic [DW-1:0] ed;
    logic [TW-1:0] et;
    er = expq[cyc].valid ? 2'(expq[cyc].resp) : 2'd0;
    ed = expq[cyc].valid ? expq[cyc].data : '0;
    et = expq[cyc].valid ? expq[cyc].tag : '0;
    checks++;
    if (out_resp !== er || out_data !== ed || out_tag !== et) begin
      failures++;
      $display("FAIL out_cyc%0d got resp=%0d data=%h tag=%0d expected resp=%0d data=%h tag=%0d",
               cyc, out_resp, out_data, out_tag, er, ed, et);
    end
  end

  task automatic step(input bit rst);
    @(posedge c_clk);
    #1;
    reset = rst;
    if (rst) begin
      for (int i = 0; i <= LAT + 1; i++) expq[cyc+i] = '0;
      for (int k = 0; k < 4; k++) owner_cyc[k] = -1;
    end
  endtask

  task automatic idle(input int n, input bit rst);
    for (int i = 0; i < n; i++) begin
      step(rst);
      req_cmd_in  = 4'd0;
      req_data_in = $urandom;
      req_tag_in  = 2'($urandom);
    end
  endtask

  task automatic issue(input logic [3:0] cmd, input logic [31:0] op1, input logic [31:0] op2,
                       input logic [1:0] tag, input bit rst_op2, output int t, output pipe_stage_t e);
    step(1'b0);
    t           = cyc;
    req_cmd_in  = cmd;
    req_data_in = op1;
    req_tag_in  = tag;
    e = model_op(cmd, op1, op2, tag);
`ifdef CALC2_TAG_CHECK_EN
    if (owner_cyc[tag] > t) begin
      e.resp = RESP_ERR;
      e.data = '0;
    end else begin
      owner_cyc[tag] = t + LAT + 1;
    end
`endif
    step(rst_op2);
    req_cmd_in  = 4'($urandom_range(1, 15));
    req_data_in = op2;
    req_tag_in  = 2'($urandom);
    if (!rst_op2) expq[t+LAT+1] = e;
  endtask

  // Hand-computed literal both pins the model and becomes the DUT expectation.
  task automatic directed(input string nm, input logic [3:0] cmd, input logic [31:0] op1,
                          input logic [31:0] op2, input logic [1:0] tag,
                          input logic [1:0] xr, input logic [31:0] xd);
    int t;
    pipe_stage_t e;
    issue(cmd, op1, op2, tag, 1'b0, t, e);
    checks++;
    if (2'(e.resp) !== xr || e.data !== xd) begin
      failures++;
      $display("FAIL model_%s got resp=%0d data=%h expected resp=%0d data=%h", nm, e.resp, e.data, xr, xd);
    end
    expq[t+LAT+1].valid = 1'b1;
    expq[t+LAT+1].resp  = resp_e'(xr);
    expq[t+LAT+1].data  = xd;
    expq[t+LAT+1].tag   = tag;
  endtask

  initial begin
    int t;
    pipe_stage_t e;
    logic [3:0]  cmd;
    logic [31:0] a, b;
    bit          dup_err;
    for (int i = 0; i < MAXC; i++) expq[i] = '0;
    for (int k = 0; k < 4; k++) owner_cyc[k] = -1;

    step(1'b1);
    step(1'b1);
    #2;
    checks++;
    if (out_resp !== 2'd0 || out_data !== '0 || out_tag !== '0) begin
      failures++;
      $display("FAIL reset_state got resp=%0d data=%h tag=%0d expected all zero", out_resp, out_data, out_tag);
    end
    step(1'b1);

    directed("sub_basic", 4'd2, 32'h158, 32'h12, 2'd0, 2'd1, 32'h146);
    directed("add_basic", 4'd1, 32'h56, 32'h103, 2'd1, 2'd1, 32'h159);
    directed("add_carry", 4'd1, 32'hFFFF_FFFF, 32'h1, 2'd2, 2'd2, 32'h0);
    directed("sub_under", 4'd2, 32'h18, 32'h32, 2'd3, 2'd2, 32'h0);
    directed("shl_31", 4'd5, 32'h1, 32'd31, 2'd0, 2'd1, 32'h8000_0000);
    directed("shr_32", 4'd6, 32'h8000_0000, 32'd32, 2'd1, 2'd1, 32'h8000_0000);
    directed("sub_equal", 4'd2, 32'h77, 32'h77, 2'd2, 2'd1, 32'h0);
    idle(4, 1'b0);
    directed("invalid3", 4'd3, 32'h1234, 32'h5678, 2'd1, 2'd2, 32'h0);
    idle(6, 1'b0);

    for (int k = 0; k < 4; k++)
      directed("b2b", 4'd1, 32'(k * 16), 32'd1, 2'(k), 2'd1, 32'(k * 16 + 1));
    idle(5, 1'b0);

    issue(4'd1, 32'd10, 32'd20, 2'd0, 1'b0, t, e);
    issue(4'd1, 32'd11, 32'd21, 2'd1, 1'b1, t, e);
    idle(LAT + 3, 1'b0);

`ifdef CALC2_TAG_CHECK_EN
    dup_err = 1'b1;
`else
    dup_err = 1'b0;
`endif
    directed("tag_first", 4'd1, 32'd5, 32'd7, 2'd2, 2'd1, 32'd12);
    directed("tag_dup", 4'd1, 32'd5, 32'd8, 2'd2, dup_err ? 2'd2 : 2'd1, dup_err ? 32'd0 : 32'd13);
    idle(6, 1'b0);

    for (int n = 0; n < 400; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 4) idle(1, 1'b1);
      else if (r < 20) idle(1, 1'b0);
      else begin
        case ($urandom_range(0, 9))
          0, 1:    cmd = 4'd1;
          2, 3:    cmd = 4'd2;
          4, 5:    cmd = 4'd5;
          6, 7:    cmd = 4'd6;
          8:       cmd = 4'($urandom_range(3, 4));
          default: cmd = 4'($urandom_range(7, 15));
        endcase
        case ($urandom_range(0, 3))
          0:       a = 32'hFFFF_FFFF;
          1:       a = $urandom_range(0, 64);
          default: a = $urandom;
        endcase
        case ($urandom_range(0, 4))
          0:       b = a;
          1:       b = $urandom_range(0, 40);
          2:       b = 32'hFFFF_FFFF - a;
          3:       b = 32'hFFFF_FFFF - a + 32'd1;
          default: b = $urandom;
        endcase
        issue(cmd, a, b, 2'($urandom), ($urandom_range(0, 39) == 0), t, e);
      end
    end
    idle(LAT + 4, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
